// File: rtl/accelerator_pkg.sv
// Shared types and sizing for the APU request path between the core and the vector decoder.
package accelerator_pkg;

    localparam int APU_NARGS       = 3;
    localparam int APU_WOP         = 6;
    localparam int APU_NFLAGS      = 15;
    localparam int APU_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic [APU_NARGS-1:0][31:0] operands;
        logic [APU_WOP-1:0]         op;
        logic [APU_NFLAGS-1:0]      flags;
    } apu_req_t;

    function automatic logic is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/apu_request_queue_if.sv
// APU request/grant/completion bundle; master issues requests, slave grants them and reports completion.
interface apu_request_queue_if;
    import accelerator_pkg::*;

    logic                       req;
    logic                       gnt;
    logic [APU_NARGS-1:0][31:0] operands;
    logic [APU_WOP-1:0]         op;
    logic [APU_NFLAGS-1:0]      flags;
    logic                       rvalid;

    modport master (output req, operands, op, flags, input gnt, rvalid);
    modport slave  (input req, operands, op, flags, output gnt, rvalid);

endinterface

// File: rtl/apu_fifo.sv
// Show-ahead FIFO: RAM-style storage with a registered head-entry output that forwards a write into an emptying queue.
module apu_fifo
    import accelerator_pkg::*;
#(
    parameter int  DEPTH = APU_QUEUE_DEPTH,
    parameter type T     = apu_req_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    T               dout_reg;
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_reg;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = dout_reg;

    assign rd_ptr_next = pop_ok ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // The next head is either already in storage or is the entry being written this cycle.
    always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) begin
            dout_reg <= din;
        end else begin
            dout_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/apu_request_queue.sv
// Queues core APU requests towards the vector decoder and tracks completions of accepted instructions.
module apu_request_queue
    import accelerator_pkg::*;
#(
    parameter int DEPTH = APU_QUEUE_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset,
    apu_request_queue_if.slave   core,
    apu_request_queue_if.master  dec,
    output logic                 busy,
    output logic                 protocol_err
);

    localparam int OW = $clog2(DEPTH + 3);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("apu_request_queue: DEPTH must be a power of two and at least 2");
    end

    apu_req_t      din;
    apu_req_t      dout;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;
    logic          completion_ok;
    logic [OW-1:0] outstanding_reg;
    logic          core_rvalid_reg;
    logic          protocol_err_reg;

    assign core.gnt = !full && !reset;
    assign accept   = core.req && core.gnt;
    assign pop      = dec.req && dec.gnt;

    assign din = '{operands: core.operands, op: core.op, flags: core.flags};

    apu_fifo #(
        .DEPTH (DEPTH),
        .T     (apu_req_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assign dec.req      = !empty;
    assign dec.operands = dout.operands;
    assign dec.op       = dout.op;
    assign dec.flags    = dout.flags;

    // A completion already in flight to the core has not yet been subtracted from the counter.
    assign completion_ok = dec.rvalid && (outstanding_reg > {{(OW-1){1'b0}}, core_rvalid_reg});

    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding_reg  <= '0;
            core_rvalid_reg  <= 1'b0;
            protocol_err_reg <= 1'b0;
        end else begin
            core_rvalid_reg <= completion_ok;
            if (dec.rvalid && !completion_ok) begin
                protocol_err_reg <= 1'b1;
            end
            case ({accept, core_rvalid_reg})
                2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
                2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
                default: outstanding_reg <= outstanding_reg;
            endcase
        end
    end

    assign core.rvalid  = core_rvalid_reg;
    assign busy         = (outstanding_reg != '0);
    assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_apu_request_queue.sv
// Directed and randomized checks of apu_request_queue against a queue-based reference model.
module tb_apu_request_queue;
    import accelerator_pkg::*;

    localparam int DEPTH = APU_QUEUE_DEPTH;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic protocol_err;

    apu_request_queue_if core_if ();
    apu_request_queue_if dec_if ();

    apu_request_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .core         (core_if.slave),
        .dec          (dec_if.master),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Reference model: pending requests in order, completions still owed to the core,
    // the core completion expected this cycle, and the sticky error.
    apu_req_t mq[$];
    int       owed   = 0;
    bit       rv_m   = 1'b0;
    bit       perr_m = 1'b0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    function automatic apu_req_t mk(input logic [5:0] op, input logic [31:0] op0);
        apu_req_t r;
        r.operands    = '0;
        r.operands[0] = op0;
        r.op          = op;
        r.flags       = '0;
        return r;
    endfunction

    function automatic apu_req_t rnd_req();
        apu_req_t r;
        r.operands = {$urandom, $urandom, $urandom};
        r.op       = 6'($urandom);
        r.flags    = 15'($urandom);
        return r;
    endfunction

    // One clock cycle: drive inputs, check the grant, advance the model, then check registered outputs.
    task automatic step(input bit rst, input bit req, input apu_req_t r, input bit dgnt, input bit drv);
        bit acc;
        bit pop;
        bit fwd;
        reset            = rst;
        core_if.req      = req;
        core_if.operands = r.operands;
        core_if.op       = r.op;
        core_if.flags    = r.flags;
        dec_if.gnt       = dgnt;
        dec_if.rvalid    = drv;
        #1;
        chk("core_gnt", 96'(core_if.gnt), 96'(!rst && (mq.size() < DEPTH)));
        if (rst) begin
            mq.delete();
            owed   = 0;
            rv_m   = 1'b0;
            perr_m = 1'b0;
        end else begin
            acc = req && (mq.size() < DEPTH);
            pop = dgnt && (mq.size() > 0);
            fwd = drv && (owed > 0);
            if (drv && owed == 0) perr_m = 1'b1;
            if (pop) begin
                $display("cycle %0d pop    op=%h op0=%h", cyc, mq[0].op, mq[0].operands[0]);
                void'(mq.pop_front());
            end
            if (acc) begin
                $display("cycle %0d accept op=%h op0=%h", cyc, r.op, r.operands[0]);
                mq.push_back(r);
            end
            owed = owed + int'(acc) - int'(fwd);
            rv_m = fwd;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("dec_req", 96'(dec_if.req), 96'(mq.size() != 0));
        chk("core_rvalid", 96'(core_if.rvalid), 96'(rv_m));
        chk("busy", 96'(busy), 96'((owed + int'(rv_m)) != 0));
        chk("protocol_err", 96'(protocol_err), 96'(perr_m));
        if (mq.size() != 0) begin
            chk("dec_operands", 96'(dec_if.operands), 96'(mq[0].operands));
            chk("dec_op", 96'(dec_if.op), 96'(mq[0].op));
            chk("dec_flags", 96'(dec_if.flags), 96'(mq[0].flags));
        end
    endtask

    task automatic idle(input bit dgnt, input bit drv);
        step(1'b0, 1'b0, '0, dgnt, drv);
    endtask

    apu_req_t rr;
    bit       exp_rv   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit       exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit       drv_pat  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("rst_dec_req", 96'(dec_if.req), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));

        // Single request: visible next cycle, popped the cycle after.
        step(1'b0, 1'b1, mk(6'b000_111, 32'h0000_0057), 1'b0, 1'b0);
        chk("t1_dec_req", 96'(dec_if.req), 96'(1));
        chk("t1_op", 96'(dec_if.op), 96'(6'b000_111));
        chk("t1_op0", 96'(dec_if.operands[0]), 96'(32'h57));
        idle(1'b1, 1'b0);
        chk("t1_empty", 96'(dec_if.req), 96'(0));

        // Fill, hold a fifth request, then pop with that request still offered.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, mk(6'(i + 1), 32'(100 + i)), 1'b0, 1'b0);
        chk("full_gnt", 96'(core_if.gnt), 96'(0));
        step(1'b0, 1'b1, mk(6'h05, 32'd104), 1'b0, 1'b0);
        step(1'b0, 1'b1, mk(6'h05, 32'd104), 1'b1, 1'b0);
        chk("after_pop_gnt", 96'(core_if.gnt), 96'(1));
        chk("after_pop_head", 96'(dec_if.operands[0]), 96'(32'd101));
        step(1'b0, 1'b1, mk(6'h05, 32'd104), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1, 1'b0);
        chk("drained", 96'(dec_if.req), 96'(0));
        for (int i = 0; i < 6; i++) idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);
        chk("all_done_busy", 96'(busy), 96'(0));

        // Three accepts, then completions on relative cycles 0, 2 and 3.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(6'h10, 32'(i)), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle(1'b0, drv_pat[k]);
            chk($sformatf("rv_seq%0d", k), 96'(core_if.rvalid), 96'(exp_rv[k]));
            chk($sformatf("busy_seq%0d", k), 96'(busy), 96'(exp_busy[k]));
        end

        // Completion with nothing outstanding.
        idle(1'b0, 1'b1);
        chk("perr_set", 96'(protocol_err), 96'(1));
        idle(1'b0, 1'b0);
        chk("perr_no_rv", 96'(core_if.rvalid), 96'(0));
        chk("perr_sticky", 96'(protocol_err), 96'(1));
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("perr_cleared", 96'(protocol_err), 96'(0));
        idle(1'b0, 1'b0);

        // Reset with three entries queued.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(6'h21, 32'(i)), 1'b0, 1'b0);
        step(1'b1, 1'b1, mk(6'h22, 32'd9), 1'b0, 1'b0);
        chk("mid_rst_req", 96'(dec_if.req), 96'(0));
        chk("mid_rst_busy", 96'(busy), 96'(0));
        idle(1'b0, 1'b0);
        chk("post_rst_gnt", 96'(core_if.gnt), 96'(1));

        // Randomized traffic; requests are throttled to keep the completion counter in range.
        for (int i = 0; i < 600; i++) begin
            bit rq;
            bit dv;
            rr = rnd_req();
            rq = ($urandom_range(0, 1) == 1) && ((owed + int'(rv_m)) <= 5);
            dv = (owed > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            step($urandom_range(0, 99) == 0, rq, rr, $urandom_range(0, 1) == 1, dv);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/apu_request_queue.md
APU_REQUEST_QUEUE -- requirements
Module: apu_request_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued APU requests; it SHALL be a power of two and at least 2.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port core_apu_req, input, 1 bit: the core offers a request.
REQ-006 Port core_apu_gnt, output, 1 bit: the queue accepts the offered request.
REQ-007 Port core_apu_operands, input, 3x32 bits: operands [2:0]; [0] is the raw instruction.
REQ-008 Port core_apu_op, input, 6 bits: the funct3 and major-opcode field.
REQ-009 Port core_apu_flags, input, 15 bits: the APU flags.
REQ-010 Port core_apu_rvalid, output, 1 bit: one instruction has completed.
REQ-011 Port dec_apu_req, output, 1 bit: a head entry is valid, offered to the vector decoder.
REQ-012 Port dec_apu_gnt, input, 1 bit: the decoder takes the head entry.
REQ-013 Port dec_apu_operands, output, 3x32 bits: head-entry operands.
REQ-014 Port dec_apu_op, output, 6 bits: head-entry op.
REQ-015 Port dec_apu_flags, output, 15 bits: head-entry flags.
REQ-016 Port dec_apu_rvalid, input, 1 bit: the decoder reports completion.
REQ-017 Port busy, output, 1 bit: at least one accepted instruction has not yet been reported complete.
REQ-018 Port protocol_err, output, 1 bit: sticky flag for a completion received with nothing outstanding.

Function
REQ-019 Accept SHALL be core_apu_req AND core_apu_gnt.
- core_apu_gnt = NOT full AND NOT reset.
- core_apu_gnt SHALL NOT depend on core_apu_req.
REQ-020 An accepted request SHALL be written at the tail entry (operands, op, flags); the tail pointer SHALL advance modulo DEPTH.
REQ-021 Queue SHALL be show-ahead:
- dec_apu_req = NOT empty.
- dec_apu_* fields = head entry, all registered outputs with no combinational path from core_apu_*.
REQ-022 Pop SHALL be dec_apu_req AND dec_apu_gnt; the head pointer SHALL advance modulo DEPTH.
REQ-023 Latency: a request accepted in cycle N into an empty queue SHALL show dec_apu_req=1 in cycle N+1; there is no bypass.
REQ-024 Count SHALL range 0..DEPTH.
- Full is count==DEPTH; empty is count==0.
- Simultaneous push and pop SHALL leave count unchanged.
REQ-025 When full, a simultaneous pop SHALL NOT enable a same-cycle accept; gnt rises the following cycle.
REQ-026 When empty, dec_apu_gnt SHALL be ignored, with no pointer or count change.
REQ-027 core_apu_rvalid SHALL equal dec_apu_rvalid delayed by exactly one cycle; each decoder completion SHALL produce exactly one core completion.
REQ-028 Outstanding counter, width clog2(DEPTH+3):
- +1 on accept; -1 on core_apu_rvalid; unchanged when both occur in the same cycle.
- busy = outstanding != 0.
REQ-029 dec_apu_rvalid while outstanding==0 SHALL:
- set protocol_err until reset;
- suppress the core_apu_rvalid pulse;
- leave the counter unchanged.
REQ-030 Field order SHALL be preserved: requests reach the decoder strictly in acceptance order.

Reset
REQ-031 While reset is high at a clk edge:
- pointers, count, outstanding and protocol_err SHALL clear to 0;
- core_apu_rvalid and dec_apu_req SHALL be 0 in the following cycle.
REQ-032 While reset is high, core_apu_gnt SHALL be 0.
REQ-033 Reset mid-operation SHALL discard all queued entries with no completion for them; storage contents need no reset.

Structure
REQ-034 accelerator_pkg SHALL hold:
- apu_req_t, a packed struct {operands 3x32, op 6, flags 15};
- APU_QUEUE_DEPTH default 4.
REQ-035 Storage and pointers SHALL live in one sub-module apu_fifo (parameterised DEPTH, element type apu_req_t); the counter and rvalid logic SHALL stay in the top.

Verification
REQ-036 Reset, then one request with op=6'b000_111, operands[0]=32'h0000_0057, flags=0:
- gnt=1 at acceptance cycle 0;
- dec_apu_req=1 in cycle 1 with identical fields;
- dec_apu_gnt=1 in cycle 1 leaves the queue empty in cycle 2.
REQ-037 Four requests with dec_apu_gnt=0:
- gnt falls after the 4th accept;
- a 5th req is held with no accept;
- one pop, then gnt=1 the next cycle and the 5th is accepted.
REQ-038 Full queue, same-cycle push attempt and pop: count becomes 3 and the push is not accepted that cycle.
REQ-039 Three accepts, then dec_apu_rvalid pulses in cycles 10, 12 and 13:
- core_apu_rvalid in cycles 11, 13 and 14;
- busy falls in cycle 15.
REQ-040 dec_apu_rvalid with outstanding=0: no core_apu_rvalid, and protocol_err=1 until reset.
REQ-041 Reset asserted with 3 entries queued: the next cycle shows dec_apu_req=0, busy=0, gnt=0 during reset and gnt=1 after.
